instruction_issue_queue: RTL

Buffers the 32-bit words produced by the byte-wise instruction assembler and issues them, field-split, to the execute stage through a valid/ready handshake. It absorbs the rate mismatch between the assembler, which emits one word every four clocks, and an execute stage that can stall for arbitrary periods on memory or pixel operations. It sits directly downstream of the instruction assembler and directly upstream of the decrypt/execute datapath.

---
 rtl/instruction_issue_queue.sv | 88 ++++++++
 1 files changed

// File: rtl/instruction_issue_queue.sv
// instruction_issue_queue: circular FIFO between the instruction assembler and
// the execute stage. It issues the head word split into four byte fields
// through a valid/ready handshake, and records a sticky flag when a word is dropped.
module instruction_issue_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned NUM_OPS = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  instructionInput,
   input  logic                         instructionValid,
   input  logic                         issueReady,
   output logic                         issueValid,
   output logic [7:0]                   opcode,
   output logic [7:0]                   destField,
   output logic [7:0]                   srcAField,
   output logic [7:0]                   srcBField,
   output logic                         illegalOp,
   output logic                         queueFull,
   output logic [$clog2(DEPTH+1)-1:0]   pendingCount,
   output logic                         overflowFlag
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned WW = 32;

   logic [WW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          full;
   logic          pop;
   logic          push;
   logic [WW-1:0] head;

   // Handshake qualification: a full queue still accepts a word when the head leaves this cycle
   always_comb begin
      full = (count == CW'(DEPTH));
      pop  = (count != '0) && issueReady;
      push = instructionValid && (!full || pop);
   end

   // Storage, pointers, occupancy and the sticky drop flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= instructionInput;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (instructionValid && full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Head fields come straight from the entry at the read pointer (stale when empty)
   always_comb begin
      head         = mem[rd_ptr];
      issueValid   = (count != '0);
      opcode       = head[31:24];
      destField    = head[23:16];
      srcAField    = head[15:8];
      srcBField    = head[7:0];
      illegalOp    = issueValid && (32'(opcode) >= NUM_OPS);
      queueFull    = full;
      pendingCount = count;
      overflowFlag = overflow;
   end

endmodule
